// File: rtl/snn_pkg.sv
// Shared sizing, loader FSM states and address helper for the snn_core input-image path.
package snn_pkg;

  localparam int IMG_BITS  = 784;
  localparam int ADDR_W    = 10;
  localparam int NUM_BYTES = (IMG_BITS + 7) / 8;
  localparam int CNT_W     = $clog2(NUM_BYTES);

  typedef enum logic [1:0] {
    LOAD,
    START,
    RUN
  } loader_state_t;

  // First pixel address covered by byte k of the incoming stream.
  function automatic logic [ADDR_W-1:0] byte_base(input logic [CNT_W-1:0] k);
    return ADDR_W'(k) << 3;
  endfunction

endpackage

// File: rtl/input_ram_784x1.sv
// 784x1 image RAM: 8-pixel write lane at a base address, synchronous 1-cycle read.
module input_ram_784x1
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data
);

  logic mem [IMG_BITS];

  // Bits past the last pixel of the final byte are dropped.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if ((wr_base + ADDR_W'(b)) < ADDR_W'(IMG_BITS)) begin
          mem[wr_base + ADDR_W'(b)] <= wr_data[b];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= 1'b0;
    end else begin
      rd_data <= (rd_addr < ADDR_W'(IMG_BITS)) ? mem[rd_addr] : 1'b0;
    end
  end

endmodule

// File: rtl/snn_input_loader.sv
// Unpacks a UART byte stream into the image RAM, then kicks snn_core and latches its digit.
module snn_input_loader
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  input  logic [ADDR_W-1:0] addr_input_unit,
  output logic              q_input,
  output logic              start,
  input  logic              done,
  input  logic [3:0]        digit,
  output logic [3:0]        result,
  output logic              result_vld,
  output logic              busy,
  output logic              overrun
);

  loader_state_t     state;
  logic [CNT_W-1:0]  byte_cnt;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_base;
  logic [7:0]        wr_data;

  // Accepted bytes are staged for one cycle so the RAM write lands in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      byte_cnt   <= '0;
      start      <= 1'b0;
      result     <= '0;
      result_vld <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      wr_en      <= 1'b0;
      wr_base    <= '0;
      wr_data    <= '0;
    end else begin
      start      <= 1'b0;
      result_vld <= 1'b0;
      wr_en      <= 1'b0;
      case (state)
        LOAD: begin
          if (rx_rdy) begin
            wr_en   <= 1'b1;
            wr_base <= byte_base(byte_cnt);
            wr_data <= rx_data;
            overrun <= 1'b0;
            if (byte_cnt == CNT_W'(NUM_BYTES - 1)) begin
              byte_cnt <= '0;
              state    <= START;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        START: begin
          start <= 1'b1;
          busy  <= 1'b1;
          state <= RUN;
          if (rx_rdy) overrun <= 1'b1;
        end
        RUN: begin
          if (rx_rdy) overrun <= 1'b1;
          if (done) begin
            result     <= digit;
            result_vld <= 1'b1;
            busy       <= 1'b0;
            byte_cnt   <= '0;
            state      <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  input_ram_784x1 u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_base (wr_base),
    .wr_data (wr_data),
    .rd_addr (addr_input_unit),
    .rd_data (q_input)
  );

endmodule

// File: tb/tb_snn_input_loader.sv
// Randomized bench for snn_input_loader with a byte-level image model and a scripted snn_core.
module tb_snn_input_loader;
  import snn_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_rdy = 1'b0;
  logic [ADDR_W-1:0] addr_input_unit = '0;
  logic              q_input;
  logic              start;
  logic              done = 1'b0;
  logic [3:0]        digit = '0;
  logic [3:0]        result;
  logic              result_vld;
  logic              busy;
  logic              overrun;

  int err_cnt = 0;
  int chk_cnt = 0;
  int start_seen = 0;
  int vld_seen = 0;
  int load_cnt = 0;
  logic [7:0] img_bytes [NUM_BYTES];
  logic [3:0] last_digit = '0;

  snn_input_loader dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_rdy          (rx_rdy),
    .addr_input_unit (addr_input_unit),
    .q_input         (q_input),
    .start           (start),
    .done            (done),
    .digit           (digit),
    .result          (result),
    .result_vld      (result_vld),
    .busy            (busy),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (start) start_seen++;
    if (result_vld) vld_seen++;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pixel p is bit (p mod 8) of byte (p / 8); anything past the image reads 0.
  function automatic logic exp_pixel(input int a);
    if (a >= IMG_BITS) return 1'b0;
    return img_bytes[a / 8][a % 8];
  endfunction

  task automatic do_reset();
    rst    = 1'b1;
    rx_rdy = 1'b0;
    done   = 1'b0;
    tick();
    tick();
    rst      = 1'b0;
    load_cnt = 0;
    tick();
  endtask

  // One byte the loader is expected to accept; rx_rdy stays high across calls for back-to-back bytes.
  task automatic apply_stimulus(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    img_bytes[load_cnt] = b;
    load_cnt = (load_cnt + 1) % NUM_BYTES;
    tick();
    rx_rdy = 1'b0;
  endtask

  task automatic stream_bytes(input int n, input bit ff_last);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom);
      if (ff_last && k == n - 1) b = 8'hFF;
      apply_stimulus(b);
    end
  endtask

  task automatic read_check(input int a, input string tag);
    addr_input_unit = ADDR_W'(a);
    tick();
    check_output($sformatf("%s_px%0d", tag, a), q_input, exp_pixel(a));
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!start && n < 20) begin
      tick();
      n++;
    end
    check_output({tag, "_start_seen"}, start, 1);
  endtask

  // Scripted snn_core completion: done with a digit, result must follow one cycle later.
  task automatic respond(input logic [3:0] d, input string tag);
    done  = 1'b1;
    digit = d;
    tick();
    done  = 1'b0;
    digit = 4'($urandom);
    last_digit = d;
    check_output({tag, "_vld"}, result_vld, 1);
    check_output({tag, "_result"}, result, d);
    check_output({tag, "_busy_clr"}, busy, 0);
  endtask

  initial begin
    int s0, v0;
    logic [3:0] d;

    // Reset values
    do_reset();
    check_output("rst_q_input", q_input, 0);
    check_output("rst_start", start, 0);
    check_output("rst_result", result, 0);
    check_output("rst_result_vld", result_vld, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_overrun", overrun, 0);

    // done while loading is ignored
    done = 1'b1; digit = 4'd9;
    tick();
    done = 1'b0;
    check_output("idle_done_vld", result_vld, 0);
    check_output("idle_done_result", result, 0);
    check_output("idle_done_busy", busy, 0);

    // 98 x 0xA5: start exactly two cycles after the last byte
    do_reset();
    s0 = start_seen;
    for (int k = 0; k < NUM_BYTES; k++) apply_stimulus(8'hA5);
    check_output("a5_start_early", start, 0);
    tick();
    check_output("a5_start_pulse", start, 1);
    check_output("a5_busy", busy, 1);
    tick();
    check_output("a5_start_once", start, 0);
    for (int a = 0; a < 8; a++) read_check(a, "a5");
    respond(4'd7, "a5");
    tick();
    check_output("a5_vld_one_cycle", result_vld, 0);
    check_output("a5_start_count", start_seen - s0, 1);

    // Partial load discarded by reset, then a fresh image
    do_reset();
    s0 = start_seen;
    stream_bytes(50, 0);
    tick();
    tick();
    check_output("partial_no_start", start_seen - s0, 0);
    do_reset();
    stream_bytes(NUM_BYTES, 0);
    wait_start("fresh");
    for (int i = 0; i < 12; i++) read_check(int'($urandom_range(0, IMG_BITS - 1)), "fresh");
    check_output("fresh_start_count", start_seen - s0, 1);
    d = 4'($urandom);
    respond(d, "fresh");
    tick();

    // Overrun during RUN: byte dropped, RAM and result untouched
    stream_bytes(NUM_BYTES, 0);
    wait_start("ovr");
    rx_data = ~img_bytes[0];
    rx_rdy  = 1'b1;
    tick();
    rx_rdy = 1'b0;
    tick();
    check_output("ovr_flag", overrun, 1);
    check_output("ovr_busy", busy, 1);
    check_output("ovr_result_kept", result, last_digit);
    for (int a = 0; a < 8; a++) read_check(a, "ovr");
    // rx_rdy and done together: done wins, byte still counted as overrun
    d = 4'($urandom);
    rx_rdy = 1'b1;
    rx_data = 8'h00;
    respond(d, "ovr_done");
    rx_rdy = 1'b0;
    check_output("ovr_done_flag", overrun, 1);
    tick();
    // Next image ends in 0xFF; its first byte clears overrun
    apply_stimulus(8'($urandom));
    check_output("ovr_cleared", overrun, 0);
    stream_bytes(NUM_BYTES - 1, 1);
    wait_start("ff");
    for (int a = IMG_BITS - 8; a < IMG_BITS; a++) read_check(a, "ff");
    read_check(IMG_BITS, "ff_oob");
    read_check(1023, "ff_oob");
    for (int i = 0; i < 4; i++) read_check(int'($urandom_range(IMG_BITS, 1023)), "ff_oob");

    // Back-to-back images, no idle cycles between done and the next byte
    s0 = start_seen;
    v0 = vld_seen;
    d = 4'($urandom);
    respond(d, "b2b0");
    stream_bytes(NUM_BYTES, 0);
    wait_start("b2b1");
    for (int i = 0; i < 6; i++) read_check(int'($urandom_range(0, IMG_BITS - 1)), "b2b1");
    d = 4'($urandom);
    respond(d, "b2b1");
    stream_bytes(NUM_BYTES, 0);
    wait_start("b2b2");
    d = 4'($urandom);
    respond(d, "b2b2");
    tick();
    tick();
    check_output("b2b_start_count", start_seen - s0, 2);
    check_output("b2b_vld_count", vld_seen - v0, 3);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
